// File: rtl/cache_l2_fa.sv
// Fully associative, write-back / write-allocate L2 with true-LRU replacement.
// Serves one blocking L1 request at a time and talks to memory one block at a time.
module cache_l2_fa #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 17,
    parameter int N_BLK  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                l1_req,
    input  logic                l1_wren,
    input  logic [ADDR_W-1:0]   l1_addr,
    input  logic [DATA_W-1:0]   l1_wdata,
    output logic                l1_ready,
    output logic                l1_done,
    output logic                l1_hit,
    output logic [2*DATA_W-1:0] l1_rdata,
    output logic                mem_req,
    output logic                mem_wren,
    output logic [ADDR_W-2:0]   mem_addr,
    output logic [2*DATA_W-1:0] mem_wdata,
    input  logic                mem_ack,
    input  logic [2*DATA_W-1:0] mem_rdata
);
    localparam int TAG_W = ADDR_W - 1;
    localparam int BLK_W = 2 * DATA_W;
    localparam int IDX_W = $clog2(N_BLK);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wren_q, wren_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               hit_q, hit_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gap_q, gap_d;
    logic [N_BLK-1:0]   valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q [N_BLK];
    logic [TAG_W-1:0]   tag_d [N_BLK];
    logic [BLK_W-1:0]   data_q [N_BLK];
    logic [BLK_W-1:0]   data_d [N_BLK];
    logic [IDX_W-1:0]   age_q [N_BLK];
    logic [IDX_W-1:0]   age_d [N_BLK];

    logic [TAG_W-1:0]   req_tag;
    logic               hit_any, inv_any;
    logic [IDX_W-1:0]   hit_idx, victim_idx;
    logic               lru_touch;
    logic [IDX_W-1:0]   lru_idx;

    function automatic logic [BLK_W-1:0] merge_word(input logic [BLK_W-1:0] blk,
                                                    input logic sel,
                                                    input logic [DATA_W-1:0] w);
        logic [BLK_W-1:0] r;
        r = blk;
        if (sel) r[BLK_W-1:DATA_W] = w;
        else     r[DATA_W-1:0]     = w;
        return r;
    endfunction

    assign req_tag = addr_q[ADDR_W-1:1];

    // Parallel tag match plus victim choice: lowest invalid entry, else the oldest.
    always_comb begin
        hit_any    = 1'b0;
        hit_idx    = '0;
        inv_any    = 1'b0;
        victim_idx = '0;
        for (int i = 0; i < N_BLK; i++) begin
            if (!hit_any && valid_q[i] && tag_q[i] == req_tag) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!inv_any && !valid_q[i]) begin
                inv_any    = 1'b1;
                victim_idx = IDX_W'(i);
            end
        end
        if (!inv_any) begin
            for (int i = 0; i < N_BLK; i++) begin
                if (age_q[i] == IDX_W'(N_BLK - 1)) victim_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wren_d    = wren_q;
        wdata_d   = wdata_q;
        hit_d     = hit_q;
        idx_d     = idx_q;
        gap_d     = 1'b0;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        tag_d     = tag_q;
        data_d    = data_q;
        age_d     = age_q;
        lru_touch = 1'b0;
        lru_idx   = idx_q;
        l1_ready  = 1'b0;
        l1_done   = 1'b0;
        l1_hit    = 1'b0;
        l1_rdata  = '0;
        mem_req   = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            S_IDLE: begin
                l1_ready = 1'b1;
                if (l1_req) begin
                    addr_d  = l1_addr;
                    wren_d  = l1_wren;
                    wdata_d = l1_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    idx_d     = hit_idx;
                    hit_d     = 1'b1;
                    lru_touch = 1'b1;
                    lru_idx   = hit_idx;
                    if (wren_q) begin
                        data_d[hit_idx]  = merge_word(data_q[hit_idx], addr_q[0], wdata_q);
                        dirty_d[hit_idx] = 1'b1;
                    end
                    state_d = S_RESP;
                end else begin
                    idx_d   = victim_idx;
                    hit_d   = 1'b0;
                    state_d = (valid_q[victim_idx] && dirty_q[victim_idx]) ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_wren  = 1'b1;
                mem_addr  = tag_q[idx_q];
                mem_wdata = data_q[idx_q];
                if (mem_ack) begin
                    valid_d[idx_q] = 1'b0;
                    gap_d          = 1'b1;
                    state_d        = S_FILL;
                end
            end
            S_FILL: begin
                // First FILL cycle after a write-back keeps mem_req low for one cycle.
                mem_req  = !gap_q;
                mem_addr = req_tag;
                if (mem_ack && !gap_q) begin
                    tag_d[idx_q]   = req_tag;
                    data_d[idx_q]  = wren_q ? merge_word(mem_rdata, addr_q[0], wdata_q)
                                            : mem_rdata;
                    valid_d[idx_q] = 1'b1;
                    dirty_d[idx_q] = wren_q;
                    lru_touch      = 1'b1;
                    state_d        = S_RESP;
                end
            end
            S_RESP: begin
                l1_done  = 1'b1;
                l1_hit   = hit_q;
                l1_rdata = data_q[idx_q];
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Younger-than-accessed entries age by one; the accessed entry becomes youngest.
        if (lru_touch) begin
            for (int j = 0; j < N_BLK; j++) begin
                if (age_q[j] < age_q[lru_idx]) age_d[j] = age_q[j] + 1'b1;
            end
            age_d[lru_idx] = '0;
        end
    end

    // NOTE: the block storage is reset too, so a post-reset lookup can never match stale tags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wren_q  <= 1'b0;
            wdata_q <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            gap_q   <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < N_BLK; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                age_q[i]  <= IDX_W'(i);
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: tb/tb_cache_l2_fa.sv
// Directed bench for cache_l2_fa: a small handshaking memory responder inside
// a transaction task, with per-scenario tasks holding hand-computed expectations.
module tb_cache_l2_fa;
    logic        clk = 1'b0;
    logic        reset;
    logic        l1_req, l1_wren;
    logic [6:0]  l1_addr;
    logic [16:0] l1_wdata;
    logic        l1_ready, l1_done, l1_hit;
    logic [33:0] l1_rdata;
    logic        mem_req, mem_wren;
    logic [5:0]  mem_addr;
    logic [33:0] mem_wdata;
    logic        mem_ack;
    logic [33:0] mem_rdata;

    cache_l2_fa dut (
        .clk(clk), .reset(reset),
        .l1_req(l1_req), .l1_wren(l1_wren), .l1_addr(l1_addr), .l1_wdata(l1_wdata),
        .l1_ready(l1_ready), .l1_done(l1_done), .l1_hit(l1_hit), .l1_rdata(l1_rdata),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int          n_wb = 0, n_fill = 0, req_drop = 0, req_cycles = 0;
    logic [5:0]  wb_addr, fill_addr;
    logic [33:0] wb_data;
    logic        x_hit;
    logic [33:0] x_rd;
    int          x_lat;

    function automatic logic [33:0] pat(input logic [5:0] tag);
        return {{11'h000, tag}, {11'h5A5, tag}};
    endfunction

    // One full L1 transaction; memory acks after dly cycles of mem_req.
    task automatic xact(input logic wr, input logic [6:0] a, input logic [16:0] wd,
                        input int dly, input logic [33:0] fd);
        int  waitc;
        bit  done_seen;
        waitc     = 0;
        done_seen = 1'b0;
        x_hit     = 1'bx;
        x_rd      = 'x;
        x_lat     = -1;
        @(negedge clk);
        l1_req   = 1'b1;
        l1_wren  = wr;
        l1_addr  = a;
        l1_wdata = wd;
        @(posedge clk);
        for (int k = 1; k <= 200 && !done_seen; k++) begin
            @(negedge clk);
            l1_req  = 1'b0;
            mem_ack = 1'b0;
            if (l1_done) begin
                done_seen = 1'b1;
                x_hit     = l1_hit;
                x_rd      = l1_rdata;
                x_lat     = k;
            end else if (mem_req) begin
                req_cycles++;
                if (waitc == dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = fd;
                    waitc     = 0;
                    if (mem_wren) begin
                        n_wb++;
                        wb_addr = mem_addr;
                        wb_data = mem_wdata;
                    end else begin
                        n_fill++;
                        fill_addr = mem_addr;
                    end
                end else begin
                    waitc++;
                end
            end else if (waitc != 0) begin
                req_drop++;
            end
        end
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL xact_timeout addr=%h got no l1_done, required l1_done within 200 cycles", a);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        l1_req    = 1'b0;
        l1_wren   = 1'b0;
        l1_addr   = '0;
        l1_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({l1_ready, l1_done, l1_hit, mem_req, mem_wren} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=10000", {l1_ready, l1_done, l1_hit, mem_req, mem_wren});
        end
        checks++;
        if ({l1_rdata, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h required all zero", l1_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_cold_read();
        int f0, w0, r0;
        f0 = n_fill; w0 = n_wb;
        xact(1'b0, 7'h05, 17'h0, 0, {17'h00AAA, 17'h00555});
        checks++;
        if (x_hit !== 1'b0) begin failures++; $display("FAIL cold_hit got=%b required=0", x_hit); end
        checks++;
        if (x_rd !== {17'h00AAA, 17'h00555}) begin
            failures++; $display("FAIL cold_rdata got=%h required=%h", x_rd, {17'h00AAA, 17'h00555});
        end
        checks++;
        if (n_fill - f0 != 1 || n_wb != w0 || fill_addr !== 6'h02) begin
            failures++;
            $display("FAIL cold_mem fills=%0d wbs=%0d addr=%h required 1 fill 0 wb addr=02", n_fill - f0, n_wb - w0, fill_addr);
        end
        checks++;
        if (x_lat != 3) begin failures++; $display("FAIL cold_latency got=%0d required=3", x_lat); end
        @(negedge clk);
        checks++;
        if (l1_ready !== 1'b1) begin failures++; $display("FAIL ready_after_done got=%b required=1", l1_ready); end

        r0 = req_cycles;
        xact(1'b0, 7'h05, 17'h0, 0, '0);
        checks++;
        if (x_hit !== 1'b1 || x_lat != 2) begin
            failures++; $display("FAIL rehit got hit=%b lat=%0d required hit=1 lat=2", x_hit, x_lat);
        end
        checks++;
        if (x_rd !== {17'h00AAA, 17'h00555} || req_cycles != r0) begin
            failures++; $display("FAIL rehit_data got=%h memcycles=%0d required=%h memcycles=0", x_rd, req_cycles - r0, {17'h00AAA, 17'h00555});
        end
    endtask

    task automatic test_write_hit();
        int r0;
        r0 = req_cycles;
        xact(1'b1, 7'h04, 17'h1FFFF, 0, '0);
        checks++;
        if (x_hit !== 1'b1 || x_rd !== {17'h00AAA, 17'h1FFFF}) begin
            failures++; $display("FAIL write_hit got hit=%b rdata=%h required hit=1 rdata=%h", x_hit, x_rd, {17'h00AAA, 17'h1FFFF});
        end
        checks++;
        if (req_cycles != r0) begin
            failures++; $display("FAIL write_hit_mem got memcycles=%0d required=0", req_cycles - r0);
        end
    endtask

    // Entry 0 holds block 02; fill 10..16, touch 02, then block 20 must evict block 10.
    task automatic test_lru_fill();
        int w0;
        for (int t = 0; t < 7; t++) begin
            logic [5:0] tag;
            tag = 6'h10 + 6'(t);
            xact(1'b0, {tag, 1'b0}, 17'h0, 0, pat(tag));
            checks++;
            if (x_hit !== 1'b0 || x_rd !== pat(tag) || fill_addr !== tag) begin
                failures++; $display("FAIL fill_%h got hit=%b rdata=%h addr=%h required hit=0 rdata=%h", tag, x_hit, x_rd, fill_addr, pat(tag));
            end
        end
        xact(1'b0, 7'h05, 17'h0, 0, '0);
        checks++;
        if (x_hit !== 1'b1) begin failures++; $display("FAIL touch_02 got=%b required=1", x_hit); end
        w0 = n_wb;
        xact(1'b0, 7'h40, 17'h0, 0, pat(6'h20));
        checks++;
        if (x_hit !== 1'b0 || n_wb != w0 || fill_addr !== 6'h20) begin
            failures++; $display("FAIL ninth_block got hit=%b wbs=%0d addr=%h required hit=0 wbs=0 addr=20", x_hit, n_wb - w0, fill_addr);
        end
        // Blocks 11..16 still resident; touching them leaves block 02 as LRU.
        for (int t = 1; t < 7; t++) begin
            logic [5:0] tag;
            tag = 6'h10 + 6'(t);
            xact(1'b0, {tag, 1'b1}, 17'h0, 0, '0);
            checks++;
            if (x_hit !== 1'b1 || x_rd !== pat(tag)) begin
                failures++; $display("FAIL retouch_%h got hit=%b rdata=%h required hit=1 rdata=%h", tag, x_hit, x_rd, pat(tag));
            end
        end
    endtask

    task automatic test_dirty_evict();
        int w0, f0;
        w0 = n_wb; f0 = n_fill; req_drop = 0;
        xact(1'b0, 7'h60, 17'h0, 5, pat(6'h30));
        checks++;
        if (n_wb - w0 != 1 || wb_addr !== 6'h02 || wb_data !== {17'h00AAA, 17'h1FFFF}) begin
            failures++; $display("FAIL evict_wb got wbs=%0d addr=%h data=%h required 1 wb addr=02 data=%h", n_wb - w0, wb_addr, wb_data, {17'h00AAA, 17'h1FFFF});
        end
        checks++;
        if (n_fill - f0 != 1 || fill_addr !== 6'h30) begin
            failures++; $display("FAIL evict_fill got fills=%0d addr=%h required 1 fill addr=30", n_fill - f0, fill_addr);
        end
        checks++;
        if (req_drop != 0) begin failures++; $display("FAIL evict_req_held got drops=%0d required=0", req_drop); end
        checks++;
        if (x_hit !== 1'b0 || x_rd !== pat(6'h30) || x_lat != 15) begin
            failures++; $display("FAIL evict_resp got hit=%b rdata=%h lat=%0d required hit=0 rdata=%h lat=15", x_hit, x_rd, x_lat, pat(6'h30));
        end
    endtask

    task automatic test_write_miss();
        int w0;
        w0 = n_wb;
        xact(1'b1, 7'h11, 17'h00123, 0, 34'h0);
        checks++;
        if (x_hit !== 1'b0 || x_rd !== {17'h00123, 17'h00000} || n_wb != w0 || fill_addr !== 6'h08) begin
            failures++; $display("FAIL write_miss got hit=%b rdata=%h wbs=%0d addr=%h required hit=0 rdata=%h wbs=0 addr=08", x_hit, x_rd, n_wb - w0, fill_addr, {17'h00123, 17'h00000});
        end
        xact(1'b0, 7'h10, 17'h0, 0, '0);
        checks++;
        if (x_hit !== 1'b1 || x_rd !== {17'h00123, 17'h00000}) begin
            failures++; $display("FAIL write_miss_readback got hit=%b rdata=%h required hit=1 rdata=%h", x_hit, x_rd, {17'h00123, 17'h00000});
        end
    endtask

    task automatic test_reset_mid_fill();
        bit seen;
        int f0;
        seen = 1'b0;
        @(negedge clk);
        l1_req  = 1'b1;
        l1_wren = 1'b0;
        l1_addr = 7'h70;
        @(posedge clk);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            l1_req = 1'b0;
            if (mem_req) seen = 1'b1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL midfill_req got mem_req=0 required mem_req=1 within 20 cycles"); end
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || l1_done !== 1'b0) begin
            failures++; $display("FAIL midfill_drop got mem_req=%b done=%b required 0/0", mem_req, l1_done);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (l1_ready !== 1'b1) begin failures++; $display("FAIL midfill_ready got=%b required=1", l1_ready); end
        mem_ack   = 1'b1;
        mem_rdata = 34'h3FFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if ({l1_ready, mem_req, l1_done} !== 3'b100) begin
            failures++; $display("FAIL stale_ack got ready/req/done=%b required=100", {l1_ready, mem_req, l1_done});
        end
        f0 = n_fill;
        xact(1'b0, 7'h70, 17'h0, 0, pat(6'h38));
        checks++;
        if (x_hit !== 1'b0 || n_fill - f0 != 1 || fill_addr !== 6'h38 || x_rd !== pat(6'h38)) begin
            failures++; $display("FAIL after_reset_miss got hit=%b fills=%0d addr=%h rdata=%h required hit=0 1 fill addr=38", x_hit, n_fill - f0, fill_addr, x_rd);
        end
        xact(1'b0, 7'h05, 17'h0, 0, pat(6'h02));
        checks++;
        if (x_hit !== 1'b0 || x_rd !== pat(6'h02)) begin
            failures++; $display("FAIL after_reset_lost got hit=%b rdata=%h required hit=0 rdata=%h", x_hit, x_rd, pat(6'h02));
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_lru_fill();
        test_dirty_evict();
        test_write_miss();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_l2_fa.md
Name: cache_l2_fa

Overview:
- Second-level cache directly downstream of the 2-way L1: serves L1 block fills and L1 write-through stores, and forwards misses and evictions to main memory.
- Fully associative, 8 blocks, 2 words per block, write-back with write-allocate, true-LRU replacement.
- Handshaked on both sides.
- One request is in flight at a time (blocking).

Parameters:
- ADDR_W, 7, word address width; addr[0] selects the word within a block, addr[ADDR_W-1:1] is the tag.
- DATA_W, 17, word width.
- N_BLK, 8, number of blocks; fixed power of two; the LRU age width is log2(N_BLK).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- l1_req  in  1  L1 request; accepted on a rising edge when l1_ready=1.
- l1_wren  in  1  1 = write one word, 0 = read the whole block.
- l1_addr  in  ADDR_W  word address.
- l1_wdata  in  DATA_W  write word.
- l1_ready  out  1  L2 idle and able to accept.
- l1_done  out  1  one-cycle pulse; the response is valid.
- l1_hit  out  1  valid with l1_done; 1 = the request hit in L2.
- l1_rdata  out  2*DATA_W  block {word1,word0} after the access; includes the merged write.
- mem_req  out  1  memory request; held until mem_ack.
- mem_wren  out  1  1 = block write-back, 0 = block fetch.
- mem_addr  out  ADDR_W-1  block address (tag).
- mem_wdata  out  2*DATA_W  write-back block.
- mem_ack  in  1  memory completes the current request; mem_rdata is valid in the same cycle for fetches.
- mem_rdata  in  2*DATA_W  fetched block.

Behaviour:
- Reset (reset=0, asynchronous):
  - All valid, dirty, tag and data bits are cleared; LRU age of entry i is i.
  - FSM goes to IDLE.
  - Outputs: l1_ready=1 (once reset releases); l1_done, l1_hit, mem_req and mem_wren are 0; l1_rdata, mem_addr and mem_wdata are 0.
- Reset mid-operation: the transaction is abandoned, mem_req drops at once, and dirty data is lost (no flush). Any mem_ack that follows is ignored.
- FSM states: IDLE, LOOKUP, WB, FILL, RESP.
- IDLE:
  - l1_ready=1.
  - When l1_req=1, latch addr/wren/wdata, drop l1_ready and go to LOOKUP.
- LOOKUP (1 cycle): compare the tag against all 8 valid entries in parallel.
  - Hit: perform the read or write on the matching entry, update LRU, go to RESP with hit=1.
  - Miss: choose a victim.
    - Victim = lowest-index invalid entry; otherwise the entry with age N_BLK-1.
    - Victim valid and dirty: go to WB. Otherwise go to FILL.
- WB:
  - mem_req=1, mem_wren=1, mem_addr = victim tag, mem_wdata = victim data.
  - On mem_ack: clear the victim's valid bit and go to FILL.
- FILL:
  - mem_req=1, mem_wren=0, mem_addr = request tag.
  - On mem_ack: install mem_rdata in the victim; valid=1, dirty=0.
  - If wren: merge wdata into word addr[0] and set dirty=1.
  - Update LRU, go to RESP with hit=0.
- mem_req deasserts in the cycle after mem_ack is sampled; WB→FILL therefore has one idle cycle on mem_req.
- RESP (1 cycle):
  - l1_done=1, l1_hit set as recorded, l1_rdata = the entry's block after the update.
  - Go to IDLE; l1_ready=1 in the next cycle.
- Latency:
  - Hit: request accepted at edge N, l1_done high in cycle N+2.
  - Miss: adds memory wait cycles plus 1 per memory transaction.
- Write hit: updates only the addressed word and sets dirty; no memory traffic.
- LRU update on every access (hit or fill):
  - Entries whose age is less than the accessed entry's old age increment by 1.
  - The accessed entry's age becomes 0.
  - Ages always form a permutation of 0..N_BLK-1.
- Requests are ignored when l1_ready=0.
- mem_ack is ignored outside WB and FILL.

Test Plan:
- Cold read addr=7'h05 → exactly one FILL for block 6'h02; mem_rdata={17'h00AAA,17'h00555} → l1_done, hit=0, l1_rdata={00AAA,00555}. Repeat the read → hit=1 with l1_done 2 cycles after acceptance, and no mem_req.
- Write hit addr=7'h04, data=17'h1FFFF after the fill above → hit=1, l1_rdata={00AAA,1FFFF}, no memory traffic, entry dirty.
- Fill 8 distinct blocks, re-read block 0, then read a 9th block → the victim is the second-filled block (age 7); because that victim is clean, no WB occurs.
- Dirty eviction: dirty block 6'h02 is the LRU entry and a miss occurs → WB with mem_addr=6'h02 and mem_wdata={00AAA,1FFFF}, then FILL. Hold mem_ack low for 5 cycles in each phase → mem_req stays high until mem_ack.
- Write miss addr=7'h11, data=17'h00123, with mem_rdata={0,0} → l1_rdata={00123,0}, hit=0, entry dirty.
- Reset pulse during FILL with mem_req high → mem_req=0 immediately and l1_ready=1 after release. A later read of the same address misses, and a stale mem_ack arriving after reset causes no state change.
